tl_sensor_conditioner: RTL and testbench

//   Front end for the trafficlight controller. Takes the raw, asynchronous
//   E/W vehicle loop and emergency-preemption inputs and synchronizes and

---
 rtl/tl_sensor_conditioner.sv | 174 +++++++++++++++++
 tb/tb_tl_sensor_conditioner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_sensor_conditioner.sv
// tl_sensor_conditioner: input front end for the trafficlight controller.
// Synchronizes and debounces the raw E/W loop and emergency inputs, queues
// E/W arrivals in a saturating counter, and turns each accepted emergency
// request into a single-cycle pulse followed by a lockout window.
// Optional build macro: TL_EMGCY_QUEUE_EN adds a 1-deep pending flag so that
// a request arriving during the pulse/lockout is served when lockout ends.
`timescale 1ns/1ps
module tl_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int EMGCY_LOCKOUT   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ew_loop_raw,
    input  logic             emgcy_raw,
    input  logic             ew_clear,
    output logic             ew_sensor,
    output logic             emgcy_sensor,
    output logic [CNT_W-1:0] ew_count,
    output logic             emgcy_lockout
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_W = $clog2(EMGCY_LOCKOUT + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(EMGCY_LOCKOUT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Index 0 carries the E/W loop, index 1 the emergency request.
    localparam int EW = 0;
    localparam int EM = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_LOCK
    } emg_state_t;

    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      stable_prev;
    logic [1:0]      rise;
    logic [DB_W-1:0] db_cnt [2];

    emg_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
`ifdef TL_EMGCY_QUEUE_EN
    logic            pending_q, pending_d;
`endif

    // Two-flop synchronizer per raw input, nothing combinational in front.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {emgcy_raw, ew_loop_raw};
            sync2 <= sync1;
        end
    end

    // Debounce: flip the stable level after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable      <= '0;
            stable_prev <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            stable_prev <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable & ~stable_prev;

    // Vehicle queue and registered demand flag; clear wins, then the
    // coincident arrival is counted on top of it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ew_count  <= '0;
            ew_sensor <= 1'b0;
        end else begin
            ew_sensor <= (ew_count != '0) | stable[EW];
            if (ew_clear) begin
                ew_count <= CNT_W'(rise[EW]);
            end else if (rise[EW] && (ew_count != CNT_MAX)) begin
                ew_count <= ew_count + 1'b1;
            end
        end
    end

    // Emergency FSM state, lockout timer and optional pending flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
`ifdef TL_EMGCY_QUEUE_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
`ifdef TL_EMGCY_QUEUE_EN
            pending_q <= pending_d;
`endif
        end
    end

    // Emergency FSM next state: requests are accepted from IDLE only.
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
`ifdef TL_EMGCY_QUEUE_EN
        pending_d = pending_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rise[EM]) state_d = ST_PULSE;
            end
            ST_PULSE: begin
                state_d = ST_LOCK;
                timer_d = TMR_LOAD;
`ifdef TL_EMGCY_QUEUE_EN
                if (rise[EM]) pending_d = 1'b1;
`endif
            end
            ST_LOCK: begin
                if (timer_q == TMR_LAST) begin
                    timer_d = '0;
`ifdef TL_EMGCY_QUEUE_EN
                    if (pending_q || rise[EM]) begin
                        state_d   = ST_PULSE;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    timer_d = timer_q - 1'b1;
`ifdef TL_EMGCY_QUEUE_EN
                    if (rise[EM]) pending_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign emgcy_sensor  = (state_q == ST_PULSE);
    assign emgcy_lockout = (state_q == ST_LOCK);

endmodule

// File: tb/tb_tl_sensor_conditioner.sv
// tb_tl_sensor_conditioner: table-driven, hand-sequenced and randomized
// checks of tl_sensor_conditioner against an event-time reference model.
`timescale 1ns/1ps
module tb_tl_sensor_conditioner;

    localparam int D  = 4;
    localparam int CW = 4;
    localparam int L  = 16;
`ifdef TL_EMGCY_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;
`else
    localparam bit QUEUE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ew_loop_raw = 1'b0;
    logic          emgcy_raw = 1'b0;
    logic          ew_clear = 1'b0;
    logic          ew_sensor;
    logic          emgcy_sensor;
    logic [CW-1:0] ew_count;
    logic          emgcy_lockout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tl_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(CW),
        .EMGCY_LOCKOUT(L)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ew_loop_raw(ew_loop_raw),
        .emgcy_raw(emgcy_raw),
        .ew_clear(ew_clear),
        .ew_sensor(ew_sensor),
        .emgcy_sensor(emgcy_sensor),
        .ew_count(ew_count),
        .emgcy_lockout(emgcy_lockout)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: synced stream is the raw samples delayed by two
    // edges; a level is accepted once the last D synced samples all
    // disagree with it. Emergency timing is tracked as the edge number of
    // the last pulse; lockout spans the L edges after it.
    int         n_edge;
    logic [D:0] m_ew_hist, m_em_hist;
    bit         m_ew_stable, m_ew_prev, m_em_stable, m_em_prev;
    int         m_count;
    bit         m_sensor;
    int         m_last_pulse;
    bit         m_pending;

    task automatic model_reset();
        m_ew_hist    = '0;
        m_em_hist    = '0;
        m_ew_stable  = 0;
        m_ew_prev    = 0;
        m_em_stable  = 0;
        m_em_prev    = 0;
        m_count      = 0;
        m_sensor     = 0;
        m_last_pulse = -1000;
        m_pending    = 0;
    endtask

    task automatic model_edge(input bit ew, input bit em, input bit clr);
        bit ew_rise, em_rise, ew_flip, em_flip, accept;
        n_edge++;
        ew_rise  = m_ew_stable && !m_ew_prev;
        em_rise  = m_em_stable && !m_em_prev;
        m_sensor = (m_count != 0) || m_ew_stable;
        if (clr)          m_count = ew_rise ? 1 : 0;
        else if (ew_rise) m_count = (m_count < (2**CW - 1)) ? m_count + 1 : m_count;
        ew_flip = m_ew_stable ? (m_ew_hist[D:1] == '0) : (&m_ew_hist[D:1]);
        em_flip = m_em_stable ? (m_em_hist[D:1] == '0) : (&m_em_hist[D:1]);
        m_ew_prev   = m_ew_stable;
        m_em_prev   = m_em_stable;
        m_ew_stable = m_ew_stable ^ ew_flip;
        m_em_stable = m_em_stable ^ em_flip;
        m_ew_hist   = {m_ew_hist[D-1:0], ew};
        m_em_hist   = {m_em_hist[D-1:0], em};
        accept = 0;
        if (em_rise && (n_edge >= m_last_pulse + L + 2)) accept = 1;
        else if (QUEUE_EN && (n_edge == m_last_pulse + L + 1) && (m_pending || em_rise)) accept = 1;
        if (accept) begin
            m_last_pulse = n_edge;
            m_pending    = 0;
        end else if (em_rise && QUEUE_EN) begin
            m_pending = 1;
        end
    endtask

    task automatic compare_model();
        check("ew_sensor", ew_sensor, m_sensor);
        check("ew_count", ew_count, m_count);
        check("emgcy_sensor", emgcy_sensor, n_edge == m_last_pulse);
        check("emgcy_lockout", emgcy_lockout, (n_edge > m_last_pulse) && (n_edge <= m_last_pulse + L));
    endtask

    // One clock: drive at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input bit ew, input bit em, input bit clr);
        ew_loop_raw = ew;
        emgcy_raw   = em;
        ew_clear    = clr;
        @(posedge clk);
        model_edge(ew, em, clr);
        #1;
        compare_model();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        ew_loop_raw = 1'b0;
        emgcy_raw   = 1'b0;
        ew_clear    = 1'b0;
        #1;
        check("rst_ew_sensor", ew_sensor, 0);
        check("rst_emgcy_sensor", emgcy_sensor, 0);
        check("rst_ew_count", ew_count, 0);
        check("rst_emgcy_lockout", emgcy_lockout, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        int hold;
        int exp_count;
        int exp_pulses;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   pulses, first_p, second_p, t;
        bit   r_ew, r_em;
        int   ew_left, em_left;

        vecs[0] = '{hold: 1, exp_count: 0, exp_pulses: 0};
        vecs[1] = '{hold: 2, exp_count: 0, exp_pulses: 0};
        vecs[2] = '{hold: 3, exp_count: 0, exp_pulses: 0};
        vecs[3] = '{hold: 4, exp_count: 1, exp_pulses: 1};
        vecs[4] = '{hold: 5, exp_count: 1, exp_pulses: 1};
        vecs[5] = '{hold: 9, exp_count: 1, exp_pulses: 1};

        n_edge = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Short glitch is ignored.
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        check("glitch_ew_sensor", ew_sensor, 0);
        check("glitch_ew_count", ew_count, 0);

        // Held loop: demand appears on the 7th edge after the first sample.
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0);
            if (i == 6) check("lat_ew_sensor_e6", ew_sensor, 0);
            if (i == 7) begin
                check("lat_ew_sensor_e7", ew_sensor, 1);
                check("lat_ew_count_e7", ew_count, 1);
            end
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        step(0, 0, 1);
        check("clear_ew_count", ew_count, 0);
        step(0, 0, 0);
        check("released_ew_sensor", ew_sensor, 0);

        // Table: pulse width vs accepted arrival / emergency pulse.
        foreach (vecs[k]) begin
            step(0, 0, 1);
            pulses = 0;
            for (int i = 0; i < vecs[k].hold; i++) begin
                step(1, 1, 0);
                pulses += int'(emgcy_sensor);
            end
            for (int i = 0; i < 24; i++) begin
                step(0, 0, 0);
                pulses += int'(emgcy_sensor);
            end
            check($sformatf("tbl%0d_ew_count", k), ew_count, vecs[k].exp_count);
            check($sformatf("tbl%0d_emgcy_pulses", k), pulses, vecs[k].exp_pulses);
        end

        // Saturation after 17 arrivals, then arrival coincident with clear.
        step(0, 0, 1);
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < 6; i++) step(1, 0, 0);
            for (int i = 0; i < 6; i++) step(0, 0, 0);
        end
        check("sat_ew_count", ew_count, 15);
        for (int i = 1; i <= 7; i++) step(1, 0, i == 7);
        check("clear_plus_arrival", ew_count, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1);

        // Two emergency requests 8 cycles apart.
        for (int i = 0; i < 24; i++) step(0, 0, 0);
        pulses   = 0;
        first_p  = -1;
        second_p = -1;
        for (t = 1; t <= 60; t++) begin
            step(0, (t <= 4) || ((t >= 9) && (t <= 12)), 0);
            if (emgcy_sensor) begin
                pulses++;
                if (first_p < 0) first_p = t;
                else if (second_p < 0) second_p = t;
            end
        end
        if (second_p < 0) second_p = first_p;
        check("two_req_pulses", pulses, QUEUE_EN ? 2 : 1);
        check("two_req_first_edge", first_p, 7);
        check("two_req_gap", second_p - first_p, QUEUE_EN ? 17 : 0);

        // Reset mid-lockout and mid-debounce, then full latency again.
        for (int i = 0; i < 24; i++) step(0, 0, 0);
        for (int i = 1; i <= 11; i++) step(i >= 10, i <= 4, 0);
        check("pre_reset_lockout", emgcy_lockout, 1);
        apply_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1, 1, 0);
            if (i == 6) begin
                check("post_rst_ew_e6", ew_sensor, 0);
                check("post_rst_em_e6", emgcy_sensor, 0);
            end
            if (i == 7) begin
                check("post_rst_ew_e7", ew_sensor, 1);
                check("post_rst_em_e7", emgcy_sensor, 1);
            end
            if (i == 8) check("post_rst_em_e8", emgcy_sensor, 0);
        end
        for (int i = 0; i < 24; i++) step(0, 0, 1);

        // Randomized segments checked every cycle against the model.
        r_ew    = 0;
        r_em    = 0;
        ew_left = 0;
        em_left = 0;
        for (int i = 0; i < 900; i++) begin
            if (i == 450) apply_reset();
            if (ew_left == 0) begin
                r_ew    = ~r_ew;
                ew_left = $urandom_range(1, 9);
            end
            if (em_left == 0) begin
                r_em    = ~r_em;
                em_left = r_em ? $urandom_range(1, 7) : $urandom_range(1, 30);
            end
            step(r_ew, r_em, $urandom_range(0, 15) == 0);
            ew_left--;
            em_left--;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
